instr_mem_server: RTL and testbench

//  Responder side of the fetch interface. Accepts the 16-bit instruction address driven by
//  the fetch stage and returns the 9-bit instruction word one cycle later.

---
 rtl/instr_mem_server.sv | 104 ++++++++++
 tb/tb_instr_mem_server.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_server.sv
// Fetch-side instruction memory: a loader FSM fills the program RAM after reset, then serves
// registered 1-cycle reads. Reads of unloaded or out-of-range addresses return HALT_INSTR and flag a fault.
module instr_mem_server #(
   parameter int unsigned        ADDR_W     = 8,
   parameter int unsigned        INSTR_W    = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
) (
   input  logic               CLK,
   input  logic               reset_ctrl,
   input  logic [15:0]        instr_addr,
   input  logic               load_en,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic               loading,
   output logic               addr_fault,
   output logic [ADDR_W:0]    load_count
);

   localparam int unsigned       DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]      count_q, count_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 valid_q, valid_d;
   logic                 fault_q, fault_d;
   logic                 wr_en;
   logic [INSTR_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]    addr_idx;
   logic                 addr_hi_nz;
   logic                 rd_fault;

   assign addr_idx   = instr_addr[ADDR_W-1:0];
   assign addr_hi_nz = (instr_addr >> ADDR_W) != 16'd0;
   // Unloaded words are unreachable: anything at or past load_count faults.
   assign rd_fault   = addr_hi_nz | ({1'b0, addr_idx} >= count_q);

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      instr_d  = HALT_INSTR;
      valid_d  = 1'b0;
      fault_d  = 1'b0;
      wr_en    = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (load_en) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
               if (wr_ptr_q != LAST_IDX) begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
               // A write into the final slot ends loading even without load_last.
               state_d = (load_last || (wr_ptr_q == LAST_IDX)) ? S_RUN : S_LOAD;
            end
         end
         S_RUN: begin
            instr_d = rd_fault ? HALT_INSTR : mem_q[addr_idx];
            valid_d = 1'b1;
            fault_d = rd_fault;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset_ctrl) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= HALT_INSTR;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
      end
   end

   // RAM is deliberately not reset; load_count gates every read.
   always_ff @(posedge CLK) begin
      if (wr_en && !reset_ctrl) begin
         mem_q[wr_ptr_q] <= load_data;
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign addr_fault  = fault_q;
   assign loading     = (state_q != S_RUN);
   assign load_count  = count_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server: loading, reads, faults, full-depth load, reset, load gaps.
module tb_instr_mem_server;

   logic        CLK = 1'b0;
   logic        reset_ctrl;
   logic [15:0] instr_addr;
   logic        load_en;
   logic [8:0]  load_data;
   logic        load_last;
   logic [8:0]  instr_out;
   logic        instr_valid;
   logic        loading;
   logic        addr_fault;
   logic [8:0]  load_count;

   int errors = 0;
   int checks = 0;

   instr_mem_server dut (
      .CLK         (CLK),
      .reset_ctrl  (reset_ctrl),
      .instr_addr  (instr_addr),
      .load_en     (load_en),
      .load_data   (load_data),
      .load_last   (load_last),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .loading     (loading),
      .addr_fault  (addr_fault),
      .load_count  (load_count)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset_ctrl = 1'b1;
      load_en    = 1'b0;
      load_last  = 1'b0;
      step();
      reset_ctrl = 1'b0;
   endtask

   task automatic load_word(input logic [8:0] d, input logic last);
      load_en   = 1'b1;
      load_data = d;
      load_last = last;
      step();
      load_en   = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic read_expect(input string nm, input logic [15:0] a,
                              input logic [8:0] exp_d, input logic exp_f);
      instr_addr = a;
      step();
      checks++;
      if (instr_out !== exp_d || instr_valid !== 1'b1 || addr_fault !== exp_f) begin
         errors++;
         $display("FAIL %s addr=%h: got out=%h valid=%b fault=%b, expected out=%h valid=1 fault=%b",
                  nm, a, instr_out, instr_valid, addr_fault, exp_d, exp_f);
      end
   endtask

   task automatic test_reset();
      instr_addr = 16'h0000;
      load_data  = 9'h000;
      do_reset();
      do_reset();
      checks++;
      if (instr_out !== 9'h1FF || instr_valid !== 1'b0 || addr_fault !== 1'b0 ||
          loading !== 1'b1 || load_count !== 9'd0) begin
         errors++;
         $display("FAIL reset_state: out=%h valid=%b fault=%b loading=%b count=%0d, expected 1ff/0/0/1/0",
                  instr_out, instr_valid, addr_fault, loading, load_count);
      end
   endtask

   task automatic test_load3();
      load_word(9'h011, 1'b0);
      checks++;
      if (loading !== 1'b1 || load_count !== 9'd1) begin
         errors++;
         $display("FAIL load3_first: loading=%b count=%0d, expected 1/1", loading, load_count);
      end
      load_word(9'h022, 1'b0);
      load_word(9'h033, 1'b1);
      checks++;
      if (loading !== 1'b0 || load_count !== 9'd3 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL load3_done: loading=%b count=%0d valid=%b, expected 0/3/0",
                  loading, load_count, instr_valid);
      end
   endtask

   task automatic test_read();
      read_expect("read0", 16'h0000, 9'h011, 1'b0);
      read_expect("read1", 16'h0001, 9'h022, 1'b0);
      read_expect("read2", 16'h0002, 9'h033, 1'b0);
   endtask

   task automatic test_fault();
      read_expect("fault_unloaded", 16'h0003, 9'h1FF, 1'b1);
      read_expect("fault_upper",    16'h0100, 9'h1FF, 1'b1);
      read_expect("fault_upper_lo", 16'h8001, 9'h1FF, 1'b1);
      read_expect("read_after_fault", 16'h0001, 9'h022, 1'b0);
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 255; i++) begin
         load_word(9'(i) ^ 9'h0A5, 1'b0);
      end
      checks++;
      if (loading !== 1'b1 || load_count !== 9'd255) begin
         errors++;
         $display("FAIL full_255: loading=%b count=%0d, expected 1/255", loading, load_count);
      end
      load_word(9'h0FF ^ 9'h0A5, 1'b0);
      checks++;
      if (loading !== 1'b0 || load_count !== 9'd256) begin
         errors++;
         $display("FAIL full_256: loading=%b count=%0d, expected 0/256", loading, load_count);
      end
      load_word(9'h000, 1'b0);
      load_word(9'h000, 1'b1);
      checks++;
      if (load_count !== 9'd256 || loading !== 1'b0) begin
         errors++;
         $display("FAIL full_extra_load: count=%0d loading=%b, expected 256/0", load_count, loading);
      end
      read_expect("full_ram0",   16'h0000, 9'h0A5, 1'b0);
      read_expect("full_ram255", 16'h00FF, 9'h05A, 1'b0);
      read_expect("full_ram128", 16'h0080, 9'h025, 1'b0);
      read_expect("full_upper",  16'h01FF, 9'h1FF, 1'b1);
   endtask

   task automatic test_reset_mid();
      // Reset while in RUN.
      instr_addr = 16'h0000;
      reset_ctrl = 1'b1;
      step();
      reset_ctrl = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || loading !== 1'b1 || instr_out !== 9'h1FF) begin
         errors++;
         $display("FAIL reset_in_run: valid=%b loading=%b out=%h, expected 0/1/1ff",
                  instr_valid, loading, instr_out);
      end
      load_word(9'h101, 1'b0);
      load_word(9'h102, 1'b0);
      reset_ctrl = 1'b1;
      load_en    = 1'b1;
      load_data  = 9'h103;
      step();
      reset_ctrl = 1'b0;
      load_en    = 1'b0;
      checks++;
      if (load_count !== 9'd0 || loading !== 1'b1 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_load: count=%0d loading=%b valid=%b, expected 0/1/0",
                  load_count, loading, instr_valid);
      end
      load_word(9'h1AB, 1'b1);
      checks++;
      if (load_count !== 9'd1 || loading !== 1'b0) begin
         errors++;
         $display("FAIL reload_one: count=%0d loading=%b, expected 1/0", load_count, loading);
      end
      read_expect("reload_addr1", 16'h0001, 9'h1FF, 1'b1);
      read_expect("reload_addr0", 16'h0000, 9'h1AB, 1'b0);
   endtask

   task automatic test_gaps();
      do_reset();
      load_word(9'h055, 1'b0);
      for (int g = 0; g < 3; g++) begin
         load_last = (g == 1);
         load_data = 9'h1EE;
         step();
         checks++;
         if (load_count !== 9'd1 || loading !== 1'b1) begin
            errors++;
            $display("FAIL gap1_%0d: count=%0d loading=%b, expected 1/1", g, load_count, loading);
         end
      end
      load_last = 1'b0;
      load_word(9'h066, 1'b0);
      for (int g = 0; g < 3; g++) begin
         step();
         checks++;
         if (load_count !== 9'd2 || loading !== 1'b1) begin
            errors++;
            $display("FAIL gap2_%0d: count=%0d loading=%b, expected 2/1", g, load_count, loading);
         end
      end
      load_word(9'h077, 1'b1);
      checks++;
      if (load_count !== 9'd3 || loading !== 1'b0) begin
         errors++;
         $display("FAIL gaps_done: count=%0d loading=%b, expected 3/0", load_count, loading);
      end
      read_expect("gaps_addr0", 16'h0000, 9'h055, 1'b0);
      read_expect("gaps_addr1", 16'h0001, 9'h066, 1'b0);
      read_expect("gaps_addr2", 16'h0002, 9'h077, 1'b0);
      read_expect("gaps_addr3", 16'h0003, 9'h1FF, 1'b1);
   endtask

   initial begin
      reset_ctrl = 1'b1;
      load_en    = 1'b0;
      load_last  = 1'b0;
      load_data  = 9'h000;
      instr_addr = 16'h0000;
      test_reset();
      test_load3();
      test_read();
      test_fault();
      test_full();
      test_reset_mid();
      test_gaps();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
